// File: rtl/mlsu_req_sched.sv
// mlsu_req_sched: round-robin scheduler for the shared MLSU request port with a
// one-entry registered output stage and outstanding-store tracking.
// Optional build macro: MLSU_REQ_LD_FENCE_EN (loads wait until no store is outstanding).
module mlsu_req_sched #(
    parameter int NrReq    = 3,
    parameter int ReqWidth = 128,
    parameter int MaxStOut = 4,
    localparam int IdxW    = $clog2(NrReq),
    localparam int CntW    = $clog2(MaxStOut + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NrReq-1:0]          req_valid_i,
    output logic [NrReq-1:0]          req_ready_o,
    input  logic [NrReq*ReqWidth-1:0] req_i,
    input  logic [NrReq-1:0]          req_is_store_i,
    output logic                      mlsu_req_valid_o,
    input  logic                      mlsu_req_ready_i,
    output logic [ReqWidth-1:0]       mlsu_req_o,
    output logic [IdxW-1:0]           mlsu_req_src_o,
    input  logic                      st_done_i,
    output logic                      st_pending_o,
    output logic [CntW-1:0]           st_cnt_o,
    output logic                      err_underflow_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e              state_r;
    state_e              state_s;
    logic [ReqWidth-1:0] payload_r;
    logic [IdxW-1:0]     src_r;
    logic [IdxW-1:0]     rr_ptr_r;
    logic                st_flag_r;
    logic [CntW-1:0]     st_cnt_r;
    logic                err_r;

    logic                stage_free_s;
    logic [NrReq-1:0]    elig_s;
    logic                grant_s;
    logic [IdxW-1:0]     grant_idx_s;
    logic [IdxW:0]       idx_s;
    logic [NrReq-1:0]    ready_s;
    logic                st_inc_s;
    logic                st_dec_s;

    assign stage_free_s = (state_r == ST_IDLE) || mlsu_req_ready_i;

    // Per-requester eligibility: stores are held back once the store budget is used up.
    always_comb begin
        elig_s = {NrReq{1'b0}};
        for (int k = 0; k < NrReq; k++) begin
            if (req_is_store_i[k]) begin
                elig_s[k] = req_valid_i[k] && (st_cnt_r < CntW'(MaxStOut));
            end else begin
`ifdef MLSU_REQ_LD_FENCE_EN
                elig_s[k] = req_valid_i[k] && (st_cnt_r == {CntW{1'b0}})
                            && !((state_r == ST_HOLD) && st_flag_r);
`else
                elig_s[k] = req_valid_i[k];
`endif
            end
        end
    end

    // Round-robin pick: first eligible requester at or above the pointer, wrapping.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = {IdxW{1'b0}};
        idx_s       = {(IdxW + 1){1'b0}};
        ready_s     = {NrReq{1'b0}};
        if (stage_free_s && !rst_i) begin
            for (int i = 0; i < NrReq; i++) begin
                idx_s = {1'b0, rr_ptr_r} + (IdxW + 1)'(i);
                idx_s = (idx_s >= (IdxW + 1)'(NrReq)) ? idx_s - (IdxW + 1)'(NrReq) : idx_s;
                grant_idx_s = (!grant_s && elig_s[idx_s[IdxW-1:0]]) ? idx_s[IdxW-1:0] : grant_idx_s;
                grant_s     = grant_s | elig_s[idx_s[IdxW-1:0]];
            end
            if (grant_s) begin
                ready_s[grant_idx_s] = 1'b1;
            end else begin
                ready_s = {NrReq{1'b0}};
            end
        end else begin
            ready_s = {NrReq{1'b0}};
        end
    end

    // Output-stage occupancy: IDLE when empty, HOLD while a request is presented.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = grant_s ? ST_HOLD : ST_IDLE;
            ST_HOLD: begin
                if (mlsu_req_ready_i) begin
                    state_s = grant_s ? ST_HOLD : ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Store counter events; a retire at zero is an underflow, not a decrement.
    always_comb begin
        st_inc_s = grant_s && req_is_store_i[grant_idx_s];
        st_dec_s = st_done_i && (st_cnt_r != {CntW{1'b0}});
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output-stage payload; only a grant may overwrite it, so it never changes while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            payload_r <= {ReqWidth{1'b0}};
            src_r     <= {IdxW{1'b0}};
            st_flag_r <= 1'b0;
            rr_ptr_r  <= {IdxW{1'b0}};
        end else if (grant_s) begin
            payload_r <= req_i[int'(grant_idx_s) * ReqWidth +: ReqWidth];
            src_r     <= grant_idx_s;
            st_flag_r <= req_is_store_i[grant_idx_s];
            rr_ptr_r  <= (grant_idx_s == IdxW'(NrReq - 1)) ? {IdxW{1'b0}} : grant_idx_s + IdxW'(1);
        end else begin
            payload_r <= payload_r;
            src_r     <= src_r;
            st_flag_r <= st_flag_r;
            rr_ptr_r  <= rr_ptr_r;
        end
    end

    // Outstanding-store count and sticky underflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_cnt_r <= {CntW{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (st_inc_s && !st_dec_s) begin
                st_cnt_r <= st_cnt_r + CntW'(1);
            end else if (!st_inc_s && st_dec_s) begin
                st_cnt_r <= st_cnt_r - CntW'(1);
            end else begin
                st_cnt_r <= st_cnt_r;
            end
            if (st_done_i && (st_cnt_r == {CntW{1'b0}})) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign req_ready_o      = ready_s;
    assign mlsu_req_valid_o = (state_r == ST_HOLD);
    assign mlsu_req_o       = payload_r;
    assign mlsu_req_src_o   = src_r;
    assign st_cnt_o         = st_cnt_r;
    assign st_pending_o     = (st_cnt_r != {CntW{1'b0}});
    assign err_underflow_o  = err_r;

endmodule

// File: doc/mlsu_req_sched.md
Name: mlsu_req_sched

Overview:
- Shares the single MLSU request port (the MLSU control machine's mlsu_req handshake) among NrReq requesters, e.g. vector load queue, vector store queue and matrix issue lanes.
- Grants requesters round-robin into a one-entry registered output stage.
- Tracks outstanding stores. Produces the store-pending level the control machine consumes as core_st_pending.
- Sits between the issue logic and the MLSU control machine.

Parameters:
- NrReq, 3, number of requesters (2..8).
- ReqWidth, 128, bit width of a flattened mlsu_init_req_t.
- MaxStOut, 4, maximum outstanding stores (1..15).
- IdxW, $clog2(NrReq), requester index width (derived, not overridable).
- CntW, $clog2(MaxStOut+1), store counter width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NrReq  per-requester request valid.
- req_ready_o  out  NrReq  per-requester grant/accept.
- req_i  in  NrReq*ReqWidth  requests; requester k occupies bits [k*ReqWidth +: ReqWidth].
- req_is_store_i  in  NrReq  request k is a store.
- mlsu_req_valid_o  out  1  request to control machine.
- mlsu_req_ready_i  in  1  control machine accepts.
- mlsu_req_o  out  ReqWidth  registered request payload.
- mlsu_req_src_o  out  IdxW  index of the granted requester.
- st_done_i  in  1  one-cycle pulse: one store fully retired (last B response).
- st_pending_o  out  1  st_cnt != 0; drives core_st_pending.
- st_cnt_o  out  CntW  outstanding store count.
- err_underflow_o  out  1  sticky: st_done_i seen while count was 0.

Behaviour:
- Reset (async, rst_i=1):
  - mlsu_req_valid_o=0, mlsu_req_o=0, mlsu_req_src_o=0.
  - Internal store flag=0, RR pointer=0, st_cnt=0.
  - st_pending_o=0, err_underflow_o=0, req_ready_o=0.
  - Reset mid-transfer drops the held request silently; no requester sees a grant during reset.
- Output stage: free when !mlsu_req_valid_o || mlsu_req_ready_i, so back-to-back grants sustain 1 request/cycle.
- Eligibility of requester k: req_valid_i[k] && (!req_is_store_i[k] || st_cnt < MaxStOut).
- Arbitration (combinational, only when the stage is free):
  - Pick the first eligible k scanning from RR pointer upward, with wrap-around.
  - req_ready_o[k]=1 for the winner only; at most one bit of req_ready_o is high.
  - req_ready_o never depends on its own requester's valid beyond eligibility.
- On grant, at the next edge:
  - Register req_i[k] and k.
  - Set mlsu_req_valid_o=1 and latch the store flag.
  - RR pointer <= (k+1) mod NrReq.
- No eligible requester while the stage is free: valid drops after the downstream handshake; pointer unchanged.
- Latency: request-to-mlsu_req_valid_o is 1 cycle.
- Payload and src are stable while valid && !ready (AXI-style; never retracted).
- Store counter:
  - +1 on grant of a store.
  - -1 on st_done_i when cnt>0.
  - Simultaneous +1 and -1: unchanged.
  - st_done_i at cnt=0: cnt stays 0, err_underflow_o <= 1 until reset.
- Counter full (cnt==MaxStOut): stores are ineligible. Loads still arbitrate and are not blocked behind the stalled store; the pointer skips the stalled store.
- States, implicit from mlsu_req_valid_o:
  - IDLE (valid=0) -> HOLD on grant.
  - HOLD -> HOLD on ready && new grant.
  - HOLD -> IDLE on ready && no grant.

Optional Feature:
- Macro: MLSU_REQ_LD_FENCE_EN.
- Defined:
  - A load is eligible only when st_cnt==0 and the held output entry is not a store.
  - Guarantees load-after-store ordering to memory at the scheduler. The store-first fence path is then unused by the control machine.
- Undefined: loads are unconstrained by outstanding stores; ordering is left to core_st_pending handling downstream.

Test Plan:
- Round-robin, NrReq=3: all three loads valid continuously, ready=1 -> mlsu_req_src_o sequence 0,1,2,0,1,2; valid high every cycle after the first.
- Backpressure: grant requester 1 with payload 0xA5..A5, ready=0 for 4 cycles -> payload and src=1 stable, req_ready_o=0 throughout; ready=1 -> next grant in the same cycle.
- Store cap, MaxStOut=4:
  - Requester 2 stores continuously, no st_done_i -> st_cnt_o 1,2,3,4, then req_ready_o[2]=0.
  - A load on requester 0 is still granted.
  - One st_done_i pulse -> cnt 3, store granted the next cycle, cnt 4.
- Simultaneous events: cnt=2, store grant and st_done_i in the same cycle -> cnt stays 2, st_pending_o=1.
- Underflow and reset: st_done_i at cnt=0 -> err_underflow_o=1, cnt=0. Assert rst_i while valid=1, asynchronously -> all outputs 0 immediately.
- Fence (macro defined): cnt=1, load valid -> no grant until st_done_i; load granted the cycle after cnt reaches 0. Macro undefined -> load granted immediately.
